// File: rtl/button_debouncer.sv
// Multi-channel push-button debouncer with press/release edge pulses.
// Each channel is synchronised, then debounced by counting consecutive
// SAMPLE_EN ticks that disagree with the current debounced level.
// Optional long-press detection is compiled in when the macro
// DEBOUNCE_LONGPRESS_EN is defined; otherwise LONG is tied to zero.
module button_debouncer #(
    parameter int NCH        = 5,
    parameter int NSAMP      = 4,
    parameter int LONG_TICKS = 1000
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           SAMPLE_EN,
    input  logic [NCH-1:0] BTN_IN,
    output logic [NCH-1:0] BTN_OUT,
    output logic [NCH-1:0] PRESS,
    output logic [NCH-1:0] RELEASE,
    output logic [NCH-1:0] LONG
);

    localparam int CW = $clog2(NSAMP + 1);

    // Reject parameter values outside the supported ranges at elaboration.
    if (NCH < 1 || NCH > 16) begin : g_bad_nch
        $error("button_debouncer: NCH out of range");
    end
    if (NSAMP < 2 || NSAMP > 15) begin : g_bad_nsamp
        $error("button_debouncer: NSAMP out of range");
    end
    if (LONG_TICKS < 2 || LONG_TICKS > 65535) begin : g_bad_long
        $error("button_debouncer: LONG_TICKS out of range");
    end

    logic [NCH-1:0] sync1_q;
    logic [NCH-1:0] sync2_q;
    logic [NCH-1:0] btn_q;
    logic [NCH-1:0] btn_d;
    logic [NCH-1:0] press_q;
    logic [NCH-1:0] press_d;
    logic [NCH-1:0] release_q;
    logic [NCH-1:0] release_d;
    logic [CW-1:0]  cnt_q [NCH];
    logic [CW-1:0]  cnt_d [NCH];

    // Two-flop synchroniser on every raw button level, running every clock.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= BTN_IN;
            sync2_q <= sync1_q;
        end
    end

    // Agreement counting: a level change is accepted after NSAMP consecutive disagreeing ticks.
    always_comb begin
        btn_d     = btn_q;
        cnt_d     = cnt_q;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SAMPLE_EN) begin
                if (sync2_q[i] != btn_q[i]) begin
                    if (cnt_q[i] == CW'(NSAMP - 1)) begin
                        btn_d[i]     = ~btn_q[i];
                        cnt_d[i]     = '0;
                        press_d[i]   = ~btn_q[i];
                        release_d[i] = btn_q[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + CW'(1);
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
    end

    // Debounced level, agreement counters and one-cycle edge pulses.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            btn_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            btn_q     <= btn_d;
            press_q   <= press_d;
            release_q <= release_d;
            cnt_q     <= cnt_d;
        end
    end

    assign BTN_OUT = btn_q;
    assign PRESS   = press_q;
    assign RELEASE = release_q;

`ifdef DEBOUNCE_LONGPRESS_EN

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    state_t         state_q [NCH];
    state_t         state_d [NCH];
    logic [15:0]    hold_q  [NCH];
    logic [15:0]    hold_d  [NCH];
    logic [NCH-1:0] long_q;
    logic [NCH-1:0] long_d;

    // Per-channel press-tracking FSM; an accepted release beats a long press on the same tick.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        long_d  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SAMPLE_EN) begin
                case (state_q[i])
                    ST_RELEASED: begin
                        if (press_d[i]) begin
                            state_d[i] = ST_PRESSED;
                            hold_d[i]  = '0;
                        end
                    end
                    ST_PRESSED: begin
                        if (release_d[i]) begin
                            state_d[i] = ST_RELEASED;
                            hold_d[i]  = '0;
                        end else if (hold_q[i] + 16'd1 == 16'(LONG_TICKS)) begin
                            state_d[i] = ST_HELD;
                            hold_d[i]  = hold_q[i] + 16'd1;
                            long_d[i]  = 1'b1;
                        end else begin
                            hold_d[i] = hold_q[i] + 16'd1;
                        end
                    end
                    ST_HELD: begin
                        if (release_d[i]) begin
                            state_d[i] = ST_RELEASED;
                            hold_d[i]  = '0;
                        end
                    end
                    default: begin
                        state_d[i] = ST_RELEASED;
                        hold_d[i]  = '0;
                    end
                endcase
            end
        end
    end

    // Press-tracking state, hold counters and the long-press pulse register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            long_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_RELEASED;
                hold_q[i]  <= '0;
            end
        end else begin
            long_q  <= long_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign LONG = long_q;

`else

    assign LONG = '0;

`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer: vector table, directed
// multi-cycle sequences and randomized stimulus against a behavioural model.
// Long-press expectations follow the DEBOUNCE_LONGPRESS_EN macro.
module tb_button_debouncer;

    localparam int NCH        = 5;
    localparam int NSAMP      = 4;
    localparam int LONG_TICKS = 8;

    logic           CLK;
    logic           RST;
    logic           SAMPLE_EN;
    logic [NCH-1:0] BTN_IN;
    logic [NCH-1:0] BTN_OUT;
    logic [NCH-1:0] PRESS;
    logic [NCH-1:0] RELEASE;
    logic [NCH-1:0] LONG;

    int checks   = 0;
    int failures = 0;

    button_debouncer #(
        .NCH       (NCH),
        .NSAMP     (NSAMP),
        .LONG_TICKS(LONG_TICKS)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .SAMPLE_EN(SAMPLE_EN),
        .BTN_IN   (BTN_IN),
        .BTN_OUT  (BTN_OUT),
        .PRESS    (PRESS),
        .RELEASE  (RELEASE),
        .LONG     (LONG)
    );

    // Free-running clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural reference: what each channel should be showing after every edge.
    logic [NCH-1:0] mSync1;
    logic [NCH-1:0] mSync2;
    logic [NCH-1:0] mLevel;
    logic [NCH-1:0] mPress;
    logic [NCH-1:0] mRelease;
    logic [NCH-1:0] mLong;
    int             mRun      [NCH];
    int             mHeld     [NCH];
    bit             mLongDone [NCH];

    task automatic modelReset();
        mSync1   = '0;
        mSync2   = '0;
        mLevel   = '0;
        mPress   = '0;
        mRelease = '0;
        mLong    = '0;
        for (int i = 0; i < NCH; i++) begin
            mRun[i]      = 0;
            mHeld[i]     = 0;
            mLongDone[i] = 1'b0;
        end
    endtask

    task automatic modelStep(input logic se, input logic [NCH-1:0] btn);
        logic [NCH-1:0] seen;
        bit             wasDown;
        seen     = mSync2;
        mSync2   = mSync1;
        mSync1   = btn;
        mPress   = '0;
        mRelease = '0;
        mLong    = '0;
        if (se) begin
            for (int i = 0; i < NCH; i++) begin
                wasDown = mLevel[i];
                if (seen[i] != mLevel[i]) begin
                    mRun[i]++;
                    if (mRun[i] == NSAMP) begin
                        mRun[i]   = 0;
                        mLevel[i] = ~mLevel[i];
                        if (mLevel[i]) mPress[i] = 1'b1;
                        else           mRelease[i] = 1'b1;
                    end
                end else begin
                    mRun[i] = 0;
                end
`ifdef DEBOUNCE_LONGPRESS_EN
                if (mPress[i]) begin
                    mHeld[i]     = 0;
                    mLongDone[i] = 1'b0;
                end else if (wasDown && !mRelease[i]) begin
                    mHeld[i]++;
                    if (mHeld[i] == LONG_TICKS && !mLongDone[i]) begin
                        mLong[i]     = 1'b1;
                        mLongDone[i] = 1'b1;
                    end
                end
`endif
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [NCH-1:0] actual,
                               input logic [NCH-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkInt(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock: drive inputs, take the edge, advance the model, compare all outputs.
    task automatic applyStimulus(input logic se, input logic [NCH-1:0] btn);
        SAMPLE_EN = se;
        BTN_IN    = btn;
        @(posedge CLK);
        modelStep(se, btn);
        #1;
        checkOutput("model_btn_out", BTN_OUT, mLevel);
        checkOutput("model_press",   PRESS,   mPress);
        checkOutput("model_release", RELEASE, mRelease);
        checkOutput("model_long",    LONG,    mLong);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic doReset();
        RST = 1'b1;
        #1;
        checkOutput("reset_btn_out", BTN_OUT, '0);
        checkOutput("reset_press",   PRESS,   '0);
        checkOutput("reset_release", RELEASE, '0);
        checkOutput("reset_long",    LONG,    '0);
        modelReset();
        @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    typedef struct {
        logic           se;
        logic [NCH-1:0] btn;
        logic [NCH-1:0] expBtn;
        logic [NCH-1:0] expPress;
        logic [NCH-1:0] expRel;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int tickNo;
        int pressTick;
        int pressCnt;
        int relCnt;
        int longCnt;
        int pressIdx;
        int longIdx;
        int gap;
        int expLongCnt;
        int expGap;
        logic [NCH-1:0] bounceSeen;
        logic [NCH-1:0] rbtn;
        logic           rse;

        RST       = 1'b1;
        SAMPLE_EN = 1'b0;
        BTN_IN    = '0;
        modelReset();

        for (int i = 0; i < 14; i++) begin
            vecs[i].se = 1'b1;
            if (i < 7) begin
                vecs[i].btn      = 5'b10001;
                vecs[i].expBtn   = (i >= 5) ? 5'b10001 : 5'b00000;
                vecs[i].expPress = (i == 5) ? 5'b10001 : 5'b00000;
                vecs[i].expRel   = 5'b00000;
            end else begin
                vecs[i].btn      = 5'b00000;
                vecs[i].expBtn   = (i >= 12) ? 5'b00000 : 5'b10001;
                vecs[i].expPress = 5'b00000;
                vecs[i].expRel   = (i == 12) ? 5'b10001 : 5'b00000;
            end
        end

        doReset();

        $display("[TB] vector table: channels 0 and 4 together, SAMPLE_EN high");
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].se, vecs[i].btn);
            checkOutput("vec_btn_out", BTN_OUT, vecs[i].expBtn);
            checkOutput("vec_press",   PRESS,   vecs[i].expPress);
            checkOutput("vec_release", RELEASE, vecs[i].expRel);
        end

        $display("[TB] slow strobe: SAMPLE_EN every 10 clocks on channel 0");
        doReset();
        tickNo    = 0;
        pressTick = -1;
        pressCnt  = 0;
        for (int c = 0; c < 60; c++) begin
            rse = ((c % 10) == 9);
            applyStimulus(rse, 5'b00001);
            if (rse) tickNo++;
            if (PRESS[0]) begin
                pressCnt++;
                pressTick = tickNo;
            end
        end
        checkInt("slow_press_tick",  pressTick, 4);
        checkInt("slow_press_count", pressCnt,  1);
        checkInt("slow_btn_out0",    int'(BTN_OUT[0]), 1);

        $display("[TB] bounce: channel 1 toggling every 3 ticks");
        doReset();
        bounceSeen = '0;
        for (int c = 0; c < 30; c++) begin
            rbtn    = '0;
            rbtn[1] = ((c / 3) % 2) == 0;
            applyStimulus(1'b1, rbtn);
            bounceSeen = bounceSeen | BTN_OUT | PRESS | RELEASE;
        end
        checkOutput("bounce_ch1_quiet", bounceSeen, '0);

        $display("[TB] long press on channel 2");
        doReset();
        pressCnt = 0;
        relCnt   = 0;
        longCnt  = 0;
        pressIdx = -1;
        longIdx  = -1;
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, (c < 26) ? 5'b00100 : 5'b00000);
            if (PRESS[2]) begin
                pressCnt++;
                pressIdx = c;
            end
            if (LONG[2]) begin
                longCnt++;
                longIdx = c;
            end
            if (RELEASE[2]) relCnt++;
        end
        gap = (longIdx < 0) ? -1 : (longIdx - pressIdx);
`ifdef DEBOUNCE_LONGPRESS_EN
        expLongCnt = 1;
        expGap     = LONG_TICKS;
`else
        expLongCnt = 0;
        expGap     = -1;
`endif
        checkInt("long_press_count",   pressCnt, 1);
        checkInt("long_long_count",    longCnt,  expLongCnt);
        checkInt("long_gap",           gap,      expGap);
        checkInt("long_release_count", relCnt,   1);

        $display("[TB] reset during press on channel 3");
        doReset();
        pressIdx = -1;
        for (int c = 0; c < 20 && pressIdx < 0; c++) begin
            applyStimulus(1'b1, 5'b01000);
            if (PRESS[3]) pressIdx = c;
        end
        checkInt("pre_reset_press_seen", int'(pressIdx >= 0), 1);
        for (int c = 0; c < 3; c++) applyStimulus(1'b1, 5'b01000);
        doReset();
        pressIdx = -1;
        relCnt   = 0;
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1'b1, 5'b01000);
            if (RELEASE[3]) relCnt++;
            if (PRESS[3] && pressIdx < 0) pressIdx = c;
        end
        checkInt("rst_repress_cycle", pressIdx, 6);
        checkInt("rst_no_release",    relCnt,   0);

        $display("[TB] 2000-tick press on channel 0");
        doReset();
        pressCnt = 0;
        relCnt   = 0;
        longCnt  = 0;
        for (int c = 0; c < 2020; c++) begin
            applyStimulus(1'b1, (c < 2006) ? 5'b00001 : 5'b00000);
            if (PRESS[0])   pressCnt++;
            if (RELEASE[0]) relCnt++;
            if (LONG != '0) longCnt++;
        end
        checkInt("hold2k_press_count",   pressCnt, 1);
        checkInt("hold2k_release_count", relCnt,   1);
        checkInt("hold2k_long_count",    longCnt,  expLongCnt);

        $display("[TB] randomized stimulus against the reference model");
        doReset();
        rbtn = '0;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) doReset();
            for (int i = 0; i < NCH; i++) begin
                if ($urandom_range(0, 5) == 0) rbtn[i] = ~rbtn[i];
            end
            rse = (c >= 2200) ? 1'b1 : ($urandom_range(0, 1) == 1);
            applyStimulus(rse, rbtn);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
